// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the next-PC / fetch-flow controller.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    FETCH      = 2'd1,
    WAIT_REDIR = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;
  localparam logic [31:0] DEF_PC_STEP      = 32'd4;

  function automatic logic [31:0] align_target(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_pend.sv
// Holds a redirect target deferred behind an outstanding fetch, and the sticky
// flag recording that some redirect target was not word aligned.
module pc_target_pend
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_chk,
  input  logic [31:0] i_target,
  output logic [31:0] o_pend_target,
  output logic        o_misalign_err
);

  logic [31:0] r_pend_target;
  logic        r_misalign_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_target  <= 32'h0;
      r_misalign_err <= 1'b0;
    end else begin
      if (i_load) begin
        r_pend_target <= align_target(i_target);
      end
      if (i_chk && (i_target[1:0] != 2'b00)) begin
        r_misalign_err <= 1'b1;
      end
    end
  end

  assign o_pend_target  = r_pend_target;
  assign o_misalign_err = r_misalign_err;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and IF/ID, ID/EX stall/flush control; redirects that arrive
// during an outstanding fetch are parked and applied when memory returns.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] PC_STEP      = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        imem_req,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        misalign_err
);

  pc_state_t   r_state;
  pc_state_t   w_state_nxt;
  logic [31:0] w_redir_raw;
  logic [31:0] w_target;
  logic [31:0] w_pend_target;
  logic        w_in_fetch;
  logic        w_in_wait;
  logic        w_pend_load;
  logic        w_target_chk;

  assign w_in_fetch  = (r_state == FETCH);
  assign w_in_wait   = (r_state == WAIT_REDIR);
  assign w_redir_raw = branch_taken ? branch_target : jump_target;
  assign w_target    = align_target(w_redir_raw);

  // Jumps are ignored while waiting, so only a branch can touch the parked target there.
  assign w_pend_load  = !reset && ((w_in_fetch && !imem_ready && (branch_taken || jump)) ||
                                   (w_in_wait && branch_taken));
  assign w_target_chk = !reset && ((w_in_fetch && (branch_taken || jump)) ||
                                   (w_in_wait && branch_taken));

  pc_target_pend u_pend (
    .clk            (clk),
    .reset          (reset),
    .i_load         (w_pend_load),
    .i_chk          (w_target_chk),
    .i_target       (w_redir_raw),
    .o_pend_target  (w_pend_target),
    .o_misalign_err (misalign_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:       w_state_nxt = FETCH;
      FETCH:      if (!imem_ready && (branch_taken || jump)) w_state_nxt = WAIT_REDIR;
      WAIT_REDIR: if (imem_ready) w_state_nxt = FETCH;
      default:    w_state_nxt = BOOT;
    endcase
  end

  always_comb begin
    pc_next    = pc_cur + PC_STEP;
    pc_en      = 1'b0;
    imem_req   = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (reset || (r_state == BOOT)) begin
      pc_next    = RESET_VECTOR;
      pc_en      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_in_fetch) begin
      imem_req = 1'b1;
      ifid_en  = 1'b1;
      if (branch_taken) begin
        pc_next    = w_target;
        pc_en      = imem_ready;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (jump) begin
        pc_next    = w_target;
        pc_en      = imem_ready;
        ifid_flush = 1'b1;
      end else if (hazard) begin
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (imem_ready) begin
        pc_en = 1'b1;
      end else begin
        ifid_flush = 1'b1;
      end
    end else if (w_in_wait) begin
      imem_req   = 1'b1;
      ifid_flush = 1'b1;
      pc_en      = imem_ready;
      // A branch resolving in the completion cycle is newer than the parked target.
      pc_next    = branch_taken ? w_target : w_pend_target;
    end else begin
      pc_next    = RESET_VECTOR;
      pc_en      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed stimulus for pc_sequencer with a per-cycle reference model and literal spot checks.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        imem_req;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_ready    (imem_ready),
    .pc_next       (pc_next),
    .pc_en         (pc_en),
    .imem_req      (imem_req),
    .ifid_en       (ifid_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .misalign_err  (misalign_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Model: booting flag, an optional parked redirect, and a sticky alignment flag.
  bit          m_live = 1'b0;
  bit          m_booting;
  bit          m_waiting;
  logic [31:0] m_pend;
  bit          m_err;

  always @(posedge clk) begin
    if (reset) begin
      m_live    = 1'b1;
      m_booting = 1'b1;
      m_waiting = 1'b0;
      m_pend    = 32'h0;
      m_err     = 1'b0;
    end else if (m_live) begin
      if (m_booting) begin
        m_booting = 1'b0;
      end else if (m_waiting) begin
        if (branch_taken) begin
          m_pend = word_of(branch_target);
          if (branch_target[1:0] != 2'b00) m_err = 1'b1;
        end
        if (imem_ready) m_waiting = 1'b0;
      end else if (branch_taken || jump) begin
        logic [31:0] t;
        t = branch_taken ? branch_target : jump_target;
        if (t[1:0] != 2'b00) m_err = 1'b1;
        if (!imem_ready) begin
          m_waiting = 1'b1;
          m_pend    = word_of(t);
        end
      end
    end
  end

  logic [31:0] e_next;
  bit e_en, e_req, e_iff, e_idf, e_ifen, c_next, c_idf, c_ifen;

  always @(negedge clk) begin
    if (m_live) begin
      e_next = pc_cur + 32'd4; e_en = 1'b0; e_req = 1'b1; e_iff = 1'b0; e_idf = 1'b0; e_ifen = 1'b1;
      c_next = 1'b0; c_idf = 1'b1; c_ifen = 1'b0;
      if (reset || m_booting) begin
        e_next = RV; e_en = 1'b1; e_req = 1'b0; e_iff = 1'b1; e_idf = 1'b1; c_next = 1'b1;
      end else if (m_waiting) begin
        e_iff = 1'b1; e_en = imem_ready; c_idf = 1'b0;
        e_next = branch_taken ? word_of(branch_target) : m_pend;
        c_next = imem_ready;
      end else if (branch_taken || jump) begin
        e_next = word_of(branch_taken ? branch_target : jump_target);
        e_en = imem_ready; e_iff = 1'b1; e_idf = branch_taken; c_next = imem_ready;
      end else if (hazard) begin
        e_idf = 1'b1; e_ifen = 1'b0; c_ifen = 1'b1;
      end else begin
        e_en = imem_ready; e_iff = !imem_ready; c_next = imem_ready; c_ifen = imem_ready;
      end
      chk("m_pc_en", {31'b0, pc_en}, {31'b0, e_en});
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, e_req});
      chk("m_ifid_flush", {31'b0, ifid_flush}, {31'b0, e_iff});
      chk("m_misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
      if (c_next) chk("m_pc_next", pc_next, e_next);
      if (c_idf)  chk("m_idex_flush", {31'b0, idex_flush}, {31'b0, e_idf});
      if (c_ifen) chk("m_ifid_en", {31'b0, ifid_en}, {31'b0, e_ifen});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc_cur = 32'h0; hazard = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; imem_ready = 1'b0;

    tick(); settle();
    chk("rst_pc_next", pc_next, RV);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd1);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    tick(); reset = 1'b0; settle();
    chk("boot_pc_next", pc_next, 32'h0000_3000);
    chk("boot_imem_req", {31'b0, imem_req}, 32'd0);
    tick(); pc_cur = 32'h3000; imem_ready = 1'b1; settle();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("seq_pc_next", pc_next, 32'h3004);
    tick(); pc_cur = 32'hFFFF_FFFC; settle();
    chk("wrap_pc_next", pc_next, 32'h0);

    tick(); pc_cur = 32'h3008; hazard = 1'b1; settle();
    chk("haz1_pc_en", {31'b0, pc_en}, 32'd0);
    chk("haz1_ifid_en", {31'b0, ifid_en}, 32'd0);
    chk("haz1_idex_flush", {31'b0, idex_flush}, 32'd1);
    tick(); settle();
    chk("haz2_pc_en", {31'b0, pc_en}, 32'd0);
    tick(); hazard = 1'b0; settle();
    chk("haz_release_pc_next", pc_next, 32'h300C);

    tick(); pc_cur = 32'h300C; branch_taken = 1'b1; branch_target = 32'h3100;
    jump = 1'b1; jump_target = 32'h3200; settle();
    chk("bj_pc_next", pc_next, 32'h3100);
    chk("bj_idex_flush", {31'b0, idex_flush}, 32'd1);

    tick(); branch_taken = 1'b0; jump = 1'b0; pc_cur = 32'h3100; imem_ready = 1'b0; settle();
    chk("bubble_ifid_flush", {31'b0, ifid_flush}, 32'd1);
    tick(); hazard = 1'b1; settle();
    chk("stall_nordy_ifid_flush", {31'b0, ifid_flush}, 32'd0);

    tick(); hazard = 1'b0; jump = 1'b1; jump_target = 32'h3400; settle();
    chk("jwait_pc_en", {31'b0, pc_en}, 32'd0);
    chk("jwait_idex_flush", {31'b0, idex_flush}, 32'd0);
    tick(); jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h3500; settle();
    chk("wait_ifid_flush", {31'b0, ifid_flush}, 32'd1);
    tick(); branch_taken = 1'b0; settle();
    chk("wait3_pc_en", {31'b0, pc_en}, 32'd0);
    tick(); imem_ready = 1'b1; settle();
    chk("redir_pc_next", pc_next, 32'h3500);
    chk("redir_pc_en", {31'b0, pc_en}, 32'd1);
    tick(); pc_cur = 32'h3500; settle();
    chk("after_redir_pc_next", pc_next, 32'h3504);

    tick(); jump = 1'b1; jump_target = 32'h3402; settle();
    chk("mis_pc_next", pc_next, 32'h3400);
    tick(); jump = 1'b0; pc_cur = 32'h3400; settle();
    chk("mis_err_set", {31'b0, misalign_err}, 32'd1);
    tick(); jump = 1'b1; jump_target = 32'h3600; imem_ready = 1'b0;
    tick(); jump = 1'b0; reset = 1'b1; settle();
    chk("rst_wait_pc_next", pc_next, RV);
    tick(); reset = 1'b0; settle();
    chk("rst_err_clear", {31'b0, misalign_err}, 32'd0);
    chk("rst_boot_req", {31'b0, imem_req}, 32'd0);
    tick(); pc_cur = 32'h3000; imem_ready = 1'b1; settle();
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
